mor1kx_dpram_fifo_ctrl: RTL and testbench

- Controller that turns an external single-clock simple dual-port RAM into a first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Owns the write/read pointers, occupancy and prefetch sequencing; drives the RAM write/read ports.
- Intended users: store buffers and similar queues in the pipeline.
- The RAM is instantiated outside this block, with the same DEPTH_WIDTH/DATA_WIDTH, 1-cycle registered read, and bypass enabled.

---
 rtl/mor1kx_dpram_fifo_ctrl.sv | 129 ++++++++++++
 tb/tb_mor1kx_dpram_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_dpram_fifo_ctrl.sv
// mor1kx_dpram_fifo_ctrl
// Turns an external single-clock simple dual-port RAM (1-cycle registered
// read, write-to-read bypass) into a first-word-fall-through FIFO with
// valid/ready handshakes on both sides. The RAM output register serves as
// the FIFO head, so the capacity is DEPTH+1 entries.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 synchronous clear of all contents (highest priority)
//   wr_valid/wr_ready     producer handshake, wr_data is the entry to push
//   rd_valid/rd_ready     consumer handshake, rd_data is the head entry
//   count                 total occupancy (entries in RAM + head register)
//   ram_waddr/ram_we/ram_din   RAM write port
//   ram_raddr/ram_re/ram_dout  RAM read port
module mor1kx_dpram_fifo_ctrl #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [DEPTH_WIDTH:0]   count,
  output logic [DEPTH_WIDTH-1:0] ram_waddr,
  output logic                   ram_we,
  output logic [DATA_WIDTH-1:0]  ram_din,
  output logic [DEPTH_WIDTH-1:0] ram_raddr,
  output logic                   ram_re,
  input  logic [DATA_WIDTH-1:0]  ram_dout
);

  localparam logic [DEPTH_WIDTH:0]   MEM_FULL = (DEPTH_WIDTH+1)'(1 << DEPTH_WIDTH);
  localparam logic [DEPTH_WIDTH:0]   CNT_ZERO = (DEPTH_WIDTH+1)'(0);
  localparam logic [DEPTH_WIDTH:0]   CNT_ONE  = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ZERO = DEPTH_WIDTH'(0);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = DEPTH_WIDTH'(1);

  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  // Entries written to the RAM but not yet fetched into the head register.
  logic [DEPTH_WIDTH:0]   mem_count_q, mem_count_d;
  logic                   rd_valid_q, rd_valid_d;

  logic wr_fire_s;
  logic out_free_s;
  logic issue_s;

  // Handshake and prefetch decisions.
  always_comb begin
    // Ready depends only on registered state and flush, never on rd_ready.
    wr_ready   = (mem_count_q != MEM_FULL) & ~flush;
    wr_fire_s  = wr_valid & wr_ready;
    out_free_s = ~rd_valid_q | rd_ready;
    // With an empty RAM, a same-cycle write is fetched through the RAM
    // bypass (raddr == waddr), giving one-cycle write-to-read latency.
    issue_s    = out_free_s & ((mem_count_q != CNT_ZERO) | wr_fire_s) & ~flush;
  end

  // Next-state computation for pointers, RAM occupancy and head valid.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    rd_valid_d  = rd_valid_q;
    if (flush) begin
      wr_ptr_d    = PTR_ZERO;
      rd_ptr_d    = PTR_ZERO;
      mem_count_d = CNT_ZERO;
      rd_valid_d  = 1'b0;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (issue_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_fire_s, issue_s})
        2'b10:   mem_count_d = mem_count_q + CNT_ONE;
        2'b01:   mem_count_d = mem_count_q - CNT_ONE;
        default: mem_count_d = mem_count_q;
      endcase
      if (issue_s) begin
        rd_valid_d = 1'b1;
      end else if (rd_ready) begin
        rd_valid_d = 1'b0;
      end else begin
        rd_valid_d = rd_valid_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      mem_count_q <= CNT_ZERO;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // RAM port drive and FIFO-side outputs. rd_data needs no holding register:
  // the RAM keeps ram_dout stable because ram_re stays low during a stall.
  always_comb begin
    ram_waddr = wr_ptr_q;
    ram_raddr = rd_ptr_q;
    ram_we    = wr_fire_s;
    ram_re    = issue_s;
    ram_din   = wr_data;
    rd_data   = ram_dout;
    rd_valid  = rd_valid_q;
    count     = mem_count_q + {{DEPTH_WIDTH{1'b0}}, rd_valid_q};
  end

endmodule

// File: tb/tb_mor1kx_dpram_fifo_ctrl.sv
module tb_mor1kx_dpram_fifo_ctrl;

  localparam int DW = 4;
  localparam int XW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [XW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [XW-1:0] rd_data;
  logic [DW:0]   count;
  logic [DW-1:0] ram_waddr;
  logic          ram_we;
  logic [XW-1:0] ram_din;
  logic [DW-1:0] ram_raddr;
  logic          ram_re;
  logic [XW-1:0] ram_dout = '0;

  int tests = 0;
  int fails = 0;
  logic [XW-1:0] sb_q[$];

  mor1kx_dpram_fifo_ctrl #(.DEPTH_WIDTH(DW), .DATA_WIDTH(XW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count),
    .ram_waddr(ram_waddr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // External RAM model: registered read, write-to-read bypass.
  logic [XW-1:0] mem [1<<DW];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    if (ram_re) ram_dout <= (ram_we && ram_waddr == ram_raddr) ? ram_din : mem[ram_raddr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: mid-cycle sampling of occupancy, head data and handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      check("sb_count", 64'(count), 64'(sb_q.size()));
      check("sb_rd_valid", 64'(rd_valid), 64'(sb_q.size() != 0));
      if (flush) begin
        sb_q.delete();
      end else begin
        if (rd_valid && rd_ready) begin
          if (sb_q.size() == 0) check("sb_underflow", 64'(1), 64'(0));
          else check("sb_rd_data", 64'(rd_data), 64'(sb_q.pop_front()));
        end
        if (wr_valid && wr_ready) sb_q.push_back(wr_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [XW-1:0] wd, input logic rr, input logic fl);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
  endtask

  task automatic drain();
    int n = 0;
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    while ((count != 0 || rd_valid) && n < 40) begin
      tick();
      #1;
      n++;
    end
    check("drain_empty", 64'(count), 64'(0));
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  typedef struct {
    logic          wv;
    logic [XW-1:0] wd;
    logic          rr;
    logic          exp_wr_ready;
    logic          exp_we;
    logic          exp_re;
    logic [DW-1:0] exp_waddr;
    logic [DW-1:0] exp_raddr;
    logic [DW:0]   exp_count;
    logic          exp_rd_valid;
    logic [XW-1:0] exp_rd_data;
  } vec_t;

  vec_t vecs[7];
  logic [XW-1:0] head;

  initial begin
    //         wv    wd            rr    rdy   we    re    wa     ra     cnt    rv    rdata
    vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 5'd0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 5'd1, 1'b1, 32'hA5A5_0001};
    vecs[2] = '{1'b1, 32'h2,         1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1, 5'd1, 1'b1, 32'hA5A5_0001};
    vecs[3] = '{1'b1, 32'h3,         1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 4'd1, 5'd2, 1'b1, 32'hA5A5_0001};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd2, 5'd2, 1'b1, 32'h2};
    vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 5'd1, 1'b1, 32'h3};
    vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 5'd0, 1'b0, 32'h0};

    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_count", 64'(count), 64'(0));
    check("rst_wr_ready", 64'(wr_ready), 64'(1));
    check("rst_ram_we", 64'(ram_we), 64'(0));
    check("rst_ram_re", 64'(ram_re), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    tick();

    // Table-driven: first write latency, stall, simultaneous push/pop, empty.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].wv, vecs[i].wd, vecs[i].rr, 1'b0);
      #1;
      check("vec_wr_ready", 64'(wr_ready), 64'(vecs[i].exp_wr_ready));
      check("vec_ram_we", 64'(ram_we), 64'(vecs[i].exp_we));
      check("vec_ram_re", 64'(ram_re), 64'(vecs[i].exp_re));
      check("vec_waddr", 64'(ram_waddr), 64'(vecs[i].exp_waddr));
      check("vec_raddr", 64'(ram_raddr), 64'(vecs[i].exp_raddr));
      check("vec_count", 64'(count), 64'(vecs[i].exp_count));
      check("vec_rd_valid", 64'(rd_valid), 64'(vecs[i].exp_rd_valid));
      if (vecs[i].exp_rd_valid) check("vec_rd_data", 64'(rd_data), 64'(vecs[i].exp_rd_data));
      tick();
    end

    // Fill to capacity DEPTH+1 with rd_ready low.
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'(k + 1), 1'b0, 1'b0);
      #1;
      check("fill_wr_ready", 64'(wr_ready), 64'(k <= 16));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("full_count", 64'(count), 64'(17));
    // Full RAM stays not-ready even while the head is being popped.
    drive(1'b1, 32'd99, 1'b1, 1'b0);
    #1;
    check("full_rdready_wr_ready", 64'(wr_ready), 64'(0));
    check("full_rdready_ram_re", 64'(ram_re), 64'(1));
    tick();
    drive(1'b1, 32'd100, 1'b0, 1'b0);
    #1;
    check("freed_wr_ready", 64'(wr_ready), 64'(1));
    tick();
    drain();

    // Streaming: one transfer per cycle, pointers wrap.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      #1;
      check("stream_count", 64'(count), 64'(i == 0 ? 0 : 1));
      check("stream_wr_ready", 64'(wr_ready), 64'(1));
      check("stream_ram_re", 64'(ram_re), 64'(1));
      tick();
    end
    drain();

    // Stall: head held, no reads issued while 3 writes land.
    head = 32'hDEAD_0004;
    drive(1'b1, head, 1'b0, 1'b0);
    tick();
    for (int s = 0; s < 5; s++) begin
      drive(s < 3, 32'h4000 + 32'(s), 1'b0, 1'b0);
      #1;
      check("stall_rd_data", 64'(rd_data), 64'(head));
      check("stall_ram_re", 64'(ram_re), 64'(0));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("stall_count", 64'(count), 64'(4));
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("stall_head_first", 64'(rd_data), 64'(head));
    drain();

    // Flush with 6 entries and a concurrent write attempt.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h5000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h5555, 1'b0, 1'b1);
    #1;
    check("flush_pre_count", 64'(count), 64'(6));
    check("flush_wr_ready", 64'(wr_ready), 64'(0));
    check("flush_ram_we", 64'(ram_we), 64'(0));
    check("flush_ram_re", 64'(ram_re), 64'(0));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("flush_count", 64'(count), 64'(0));
    check("flush_rd_valid", 64'(rd_valid), 64'(0));
    drive(1'b1, 32'hF1F1_0005, 1'b0, 1'b0);
    #1;
    check("flush_new_waddr", 64'(ram_waddr), 64'(0));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("flush_new_rd_valid", 64'(rd_valid), 64'(1));
    check("flush_new_rd_data", 64'(rd_data), 64'(32'hF1F1_0005));
    drain();

    // Asynchronous reset between edges mid-stream.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h6000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd_valid", 64'(rd_valid), 64'(0));
    check("arst_count", 64'(count), 64'(0));
    check("arst_wr_ready", 64'(wr_ready), 64'(1));
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h7777_0006, 1'b0, 1'b0);
    #1;
    check("arst_waddr", 64'(ram_waddr), 64'(0));
    check("arst_raddr", 64'(ram_raddr), 64'(0));
    check("arst_ram_re", 64'(ram_re), 64'(1));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("arst_new_rd_data", 64'(rd_data), 64'(32'h7777_0006));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
